// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-requester RAM port arbiter:
// FSM state encoding and requester IDs carried through the read-return pipe.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  localparam logic REQ_ID_M0 = 1'b0;
  localparam logic REQ_ID_M1 = 1'b1;

endpackage

// File: rtl/ram_rd_tag_pipe.sv
// Tracks outstanding RAM reads: an RD_LAT-deep {valid,id} shift register whose
// output lines up with ram_rdata for the read that loaded it.
module ram_rd_tag_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_id,
  output logic out_valid,
  output logic out_id
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] id_q, id_d;

  always_comb begin
    vld_d    = vld_q << 1;
    id_d     = id_q << 1;
    vld_d[0] = in_valid;
    id_d[0]  = in_id;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_id    = id_q[RD_LAT-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between two burst requesters with round-robin grants,
// a registered command stage and tagged read-data return.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int AW        = 6,
  parameter int DW        = 8,
  parameter int RD_LAT    = 1,
  parameter int BURST_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_valid,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_last,
  output logic          m0_ready,
  output logic          m0_rvalid,
  input  logic          m1_valid,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_last,
  output logic          m1_ready,
  output logic          m1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int            CW       = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

  arb_state_e    state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic          ram_en_q, ram_we_q, cmd_id_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_wdata_q;

  logic          sel_id, beat_acc, beat_we, beat_last;
  logic [AW-1:0] beat_addr;
  logic [DW-1:0] beat_wdata;
  logic          tag_valid, tag_id;

  always_comb begin
    m0_ready   = (state_q == ST_GNT0);
    m1_ready   = (state_q == ST_GNT1);
    sel_id     = (state_q == ST_GNT1);
    beat_acc   = (m0_ready & m0_valid) | (m1_ready & m1_valid);
    beat_we    = sel_id ? m1_we    : m0_we;
    beat_last  = sel_id ? m1_last  : m0_last;
    beat_addr  = sel_id ? m1_addr  : m0_addr;
    beat_wdata = sel_id ? m1_wdata : m0_wdata;
  end

  // A grant is held while its owner idles; only last or the beat cap releases it.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_valid && m1_valid) begin
          state_d = rr_ptr_q ? ST_GNT1 : ST_GNT0;
        end else if (m0_valid) begin
          state_d = ST_GNT0;
        end else if (m1_valid) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (beat_acc) begin
          if (beat_last || (beat_cnt_q == CNT_LAST)) begin
            state_d    = ST_IDLE;
            rr_ptr_d   = ~sel_id;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Address and data hold their last value between beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      cmd_id_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      ram_en_q <= beat_acc;
      ram_we_q <= beat_acc & beat_we;
      if (beat_acc) begin
        cmd_id_q    <= sel_id;
        ram_addr_q  <= beat_addr;
        ram_wdata_q <= beat_wdata;
      end
    end
  end

  ram_rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (ram_en_q & ~ram_we_q),
    .in_id    (cmd_id_q),
    .out_valid(tag_valid),
    .out_id   (tag_id)
  );

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign m0_rvalid = tag_valid & (tag_id == REQ_ID_M0);
  assign m1_rvalid = tag_valid & (tag_id == REQ_ID_M1);
  assign rdata     = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM model, per-requester burst drivers, and a
// scoreboard of expected commands and read returns checked by a negedge monitor.
module tb_ram_port_arbiter;

  localparam int AW        = 6;
  localparam int DW        = 8;
  localparam int RD_LAT    = 1;
  localparam int BURST_MAX = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    mv, mwe, mlast, rdy, rv;
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mwd   [2];
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;

  ram_port_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_valid (mv[0]),
    .m0_we    (mwe[0]),
    .m0_addr  (maddr[0]),
    .m0_wdata (mwd[0]),
    .m0_last  (mlast[0]),
    .m0_ready (rdy[0]),
    .m0_rvalid(rv[0]),
    .m1_valid (mv[1]),
    .m1_we    (mwe[1]),
    .m1_addr  (maddr[1]),
    .m1_wdata (mwd[1]),
    .m1_last  (mlast[1]),
    .m1_ready (rdy[1]),
    .m1_rvalid(rv[1]),
    .rdata    (rdata),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // RAM model with RD_LAT cycles from registered enable to read data.
  logic [DW-1:0] mem    [2**AW];
  logic [DW-1:0] shadow [2**AW];
  logic [DW-1:0] dpipe  [RD_LAT];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      dpipe[0] <= mem[ram_addr];
    end
    for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign ram_rdata = dpipe[RD_LAT-1];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            cyc;
  } rd_t;

  cmd_t cmd_q[$];
  rd_t  rd_q[$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  cmd_t ce;
  rd_t  re;

  always @(negedge clk) begin
    if (!rst) begin
      cmd_q.delete();
      rd_q.delete();
    end else begin
      if (cmd_q.size() > 0) begin
        ce = cmd_q.pop_front();
        check_val("cmd_en", ram_en, 1);
        check_val("cmd_we", ram_we, ce.we);
        check_val("cmd_addr", ram_addr, ce.addr);
        if (ce.we) check_val("cmd_wdata", ram_wdata, ce.wdata);
      end else begin
        check_val("cmd_idle_en", ram_en, 0);
      end
      if (rv != 2'b00) begin
        check_val("rvalid_both", rv[0] & rv[1], 0);
        if (rd_q.size() == 0) begin
          check_val("rvalid_unexp", rd_q.size(), 1);
        end else begin
          re = rd_q.pop_front();
          check_val("rd_id", rv[1], re.id);
          check_val("rd_data", rdata, re.data);
          check_val("rd_cycle", cyc, re.cyc);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (mv[i] && rdy[i]) begin
          cmd_q.push_back('{mwe[i], maddr[i], mwd[i]});
          grant_log.push_back(i);
          if (mwe[i]) shadow[maddr[i]] = mwd[i];
          else rd_q.push_back('{i[0], shadow[maddr[i]], cyc + 1 + RD_LAT});
        end
      end
    end
  end

  // Caller must be at posedge+#1; returns at posedge+#1 after the final beat.
  task automatic run_burst(input int id, input int n, input logic we, input logic [AW-1:0] a0,
                           input logic [DW-1:0] d0, input logic [DW-1:0] dstep, input logic use_last);
    int waited;
    for (int b = 0; b < n; b++) begin
      mv[id]    = 1'b1;
      mwe[id]   = we;
      maddr[id] = a0 + AW'(b);
      mwd[id]   = d0 + DW'(dstep * DW'(b));
      mlast[id] = use_last && (b == n - 1);
      waited    = 0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          mv[id] = 1'b0;
          mlast[id] = 1'b0;
          return;
        end
        if (rdy[id]) break;
        waited++;
        if (waited > 200) begin
          check_val("beat_timeout", rdy[id], 1);
          mv[id] = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    mv[id]    = 1'b0;
    mlast[id] = 1'b0;
  endtask

  task automatic compare_log(input string tag, input int exp_q[$]);
    check_val({tag, "_len"}, grant_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++)
      check_val(tag, grant_log[i], exp_q[i]);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    grant_log.delete();
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_ram_en"}, ram_en, 0);
    check_val({tag, "_ram_we"}, ram_we, 0);
    check_val({tag, "_ram_addr"}, ram_addr, 0);
    check_val({tag, "_ram_wdata"}, ram_wdata, 0);
    check_val({tag, "_ready"}, rdy, 0);
    check_val({tag, "_rvalid"}, rv, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int exp_q[$];

  initial begin
    mv = '0; mwe = '0; mlast = '0;
    for (int i = 0; i < 2; i++) begin
      maddr[i] = '0;
      mwd[i]   = '0;
    end
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]    = DW'(i) ^ 8'h3C;
      shadow[i] = DW'(i) ^ 8'h3C;
    end
    repeat (3) @(posedge clk);
    #1 check_quiet("reset");
    rst = 1'b1;

    // 1) m0 writes A0..A3 to 0..3, then arbiter returns to IDLE
    @(posedge clk); #1;
    run_burst(0, 4, 1'b1, 6'd0, 8'hA0, 8'h01, 1'b1);
    check_val("t1_ready_after", rdy, 0);
    @(posedge clk); #1;
    check_val("t1_ready_idle", rdy, 0);
    exp_q = '{0, 0, 0, 0};
    compare_log("t1_order", exp_q);

    // 2) both request from reset: m0, m1, m0
    do_reset();
    @(posedge clk); #1;
    fork
      begin
        run_burst(0, 2, 1'b1, 6'd10, 8'h10, 8'h01, 1'b1);
        run_burst(0, 2, 1'b1, 6'd12, 8'h12, 8'h01, 1'b1);
      end
      run_burst(1, 2, 1'b1, 6'd20, 8'h20, 8'h01, 1'b1);
    join
    exp_q = '{0, 0, 1, 1, 0, 0};
    compare_log("t2_order", exp_q);

    // 3) m1 32 beats without last, m0 waiting: cap at BURST_MAX
    grant_log.delete();
    @(posedge clk); #1;
    fork
      run_burst(1, 32, 1'b1, 6'd32, 8'h00, 8'h01, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1 run_burst(0, 1, 1'b1, 6'd30, 8'hEE, 8'h00, 1'b1);
      end
    join
    exp_q.delete();
    for (int i = 0; i < BURST_MAX; i++) exp_q.push_back(1);
    exp_q.push_back(0);
    for (int i = 0; i < 32 - BURST_MAX; i++) exp_q.push_back(1);
    compare_log("t3_order", exp_q);

    // 4) m0 writes 55/66 to 5/6, reads them back-to-back
    @(posedge clk); #1;
    run_burst(0, 2, 1'b1, 6'd5, 8'h55, 8'h11, 1'b1);
    run_burst(0, 2, 1'b0, 6'd5, 8'h00, 8'h00, 1'b1);
    repeat (RD_LAT + 3) @(posedge clk);
    #1 check_val("t4_drain", rd_q.size(), 0);

    // 5) interleaved single reads from both requesters
    fork
      repeat (3) run_burst(0, 1, 1'b0, 6'd1, 8'h00, 8'h00, 1'b1);
      repeat (3) run_burst(1, 1, 1'b0, 6'd2, 8'h00, 8'h00, 1'b1);
    join
    repeat (RD_LAT + 3) @(posedge clk);
    #1 check_val("t5_drain", rd_q.size(), 0);

    // 6) reset mid-burst with reads in flight
    fork
      run_burst(0, 10, 1'b0, 6'd0, 8'h00, 8'h00, 1'b0);
      begin
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1 check_quiet("t6_reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
      end
    join
    repeat (6) begin
      @(negedge clk);
      check_val("t6_stale_rvalid", rv, 0);
    end
    @(posedge clk); #1;
    run_burst(1, 1, 1'b0, 6'd5, 8'h00, 8'h00, 1'b1);
    repeat (RD_LAT + 3) @(posedge clk);
    #1 check_val("final_drain", rd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
